// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and shared-memory ports around mem_arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              dm_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins by default; a fetch starved for STARVE_MAX data grants is forced.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q,    if_ack_d;
  logic              dm_ack_q,    dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  logic if_elig_s;
  logic dm_elig_s;
  logic fetch_win_s;

  // A requester whose ack is showing this cycle is still holding req from the finished transfer.
  assign if_elig_s   = bus.if_req & ~if_ack_q;
  assign dm_elig_s   = bus.dm_req & ~dm_ack_q;
  assign fetch_win_s = if_elig_s & ((starve_cnt_q == STARVE_LIM) | ~dm_elig_s);

  // Next-state, grant and completion logic.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE: begin
        if (fetch_win_s) begin
          state_d      = IF_BUSY;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end else if (dm_elig_s) begin
          state_d     = DM_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          if (bus.if_req && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      IF_BUSY: begin
        if (bus.mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_rdata;
        end else begin
          state_d = IF_BUSY;
        end
      end
      DM_BUSY: begin
        if (bus.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          dm_ack_d  = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
        end else begin
          state_d = DM_BUSY;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_stall  = bus.if_req & ~if_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_ack_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus queues expected grants and acks,
// a monitor checks them as the DUT presents them, a responder models memory.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      exp_g[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_dm[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int          resp_delay  = 0;
  int          resp_cnt    = 0;
  logic        resp_ready  = 1'b0;
  logic        ready_force = 1'b0;
  logic [31:0] resp_data   = 32'd0;

  assign bus.mem_ready = resp_ready | ready_force;
  assign bus.mem_rdata = resp_data;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic flag(input string nm);
    chk_cnt++;
    $display("FAIL %s: event seen/missing at %0t", nm, $time);
  endtask

  // Memory model: raise mem_ready after resp_delay busy cycles, for one cycle.
  always @(negedge clk) begin
    if (rst || !bus.mem_req || resp_ready) begin
      resp_ready = 1'b0;
      resp_cnt   = 0;
    end else if (resp_cnt >= resp_delay) begin
      resp_ready = 1'b1;
    end else begin
      resp_cnt++;
    end
  end

  // Monitor: compare grants, bus stability and acks against the queues.
  grant_t cur_exp;
  logic   mem_req_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.mem_req && !mem_req_prev) begin
        if (exp_g.size() == 0) flag("unexpected_grant");
        else begin
          cur_exp = exp_g.pop_front();
          check("grant_we",    64'(bus.mem_we),    64'(cur_exp.we));
          check("grant_addr",  64'(bus.mem_addr),  64'(cur_exp.addr));
          check("grant_wdata", 64'(bus.mem_wdata), 64'(cur_exp.wdata));
        end
      end else if (bus.mem_req) begin
        check("stable_bus", {31'd0, bus.mem_we, bus.mem_addr},
              {31'd0, cur_exp.we, cur_exp.addr});
      end
      if (bus.if_ack) begin
        if (exp_if.size() == 0) flag("unexpected_if_ack");
        else check("if_rdata", 64'(bus.if_rdata), 64'(exp_if.pop_front()));
      end
      if (bus.dm_ack) begin
        if (exp_dm.size() == 0) flag("unexpected_dm_ack");
        else check("dm_rdata", 64'(bus.dm_rdata), 64'(exp_dm.pop_front()));
      end
    end
    mem_req_prev = bus.mem_req;
  end

  task automatic wait_ack(input bit is_if, input string nm);
    int n = 0;
    while (!(is_if ? bus.if_ack : bus.dm_ack) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) flag(nm);
  endtask

  task automatic fetch_only(input logic [31:0] a, input logic [31:0] d, input int dly);
    int stalls = 0;
    int n = 0;
    resp_data  = d;
    resp_delay = dly;
    exp_g.push_back('{1'b0, a, 32'd0});
    exp_if.push_back(d);
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    #1;
    while (!bus.if_ack && n < 100) begin
      stalls += int'(bus.if_stall);
      @(negedge clk);
      n++;
    end
    if (n >= 100) flag("fetch_ack_timeout");
    bus.if_req = 1'b0;
    check("if_stall_cycles", 64'(stalls), 64'(2 + dly));
  endtask

  initial begin
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'd0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'd0;
    bus.dm_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_mem_req",   64'(bus.mem_req),   64'd0);
    check("rst_mem_bus",   {31'd0, bus.mem_we, bus.mem_addr}, 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_acks",      64'({bus.if_ack, bus.dm_ack}), 64'd0);
    check("rst_rdata",     {bus.if_rdata, bus.dm_rdata}, 64'd0);
    check("rst_starve",    64'(dut.starve_cnt_q), 64'd0);
    rst = 1'b0;

    // Fetch alone, minimum latency.
    fetch_only(32'h0000_0100, 32'h2402_000A, 0);

    // Contention: write wins, fetch granted in the dm_ack cycle.
    resp_data  = 32'h1111_2222;
    resp_delay = 0;
    exp_g.push_back('{1'b1, 32'h0000_0040, 32'hDEAD_BEEF});
    exp_g.push_back('{1'b0, 32'h0000_0200, 32'd0});
    exp_dm.push_back(32'd0);
    exp_if.push_back(32'h1111_2222);
    @(negedge clk);
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0200;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h0000_0040;
    bus.dm_wdata = 32'hDEAD_BEEF;
    #1;
    check("both_stall", 64'({bus.if_stall, bus.dm_stall}), 64'd3);
    wait_ack(1'b0, "contention_dm_ack_timeout");
    bus.dm_req = 1'b0;
    @(negedge clk);
    check("b2b_fetch_req", 64'({bus.mem_req, bus.mem_we}), 64'd2);
    wait_ack(1'b1, "contention_if_ack_timeout");
    bus.if_req = 1'b0;

    // Starvation: four data reads, then the forced fetch, then one more read.
    resp_data = 32'hCAFE_0001;
    for (int k = 0; k < 4; k++) begin
      exp_g.push_back('{1'b0, 32'h0000_0044, 32'd0});
      exp_dm.push_back(32'hCAFE_0001);
    end
    exp_g.push_back('{1'b0, 32'h0000_0300, 32'd0});
    exp_if.push_back(32'hCAFE_0001);
    exp_g.push_back('{1'b0, 32'h0000_0044, 32'd0});
    exp_dm.push_back(32'hCAFE_0001);
    @(negedge clk);
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0000_0300;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h0000_0044;
    bus.dm_wdata = 32'd0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(1'b0, "starve_dm_ack_timeout");
      bus.if_req = 1'b0;
      @(negedge clk);
      bus.if_req = 1'b1;
    end
    check("starve_cnt_sat", 64'(dut.starve_cnt_q), 64'd4);
    wait_ack(1'b1, "starve_if_ack_timeout");
    check("starve_cnt_clr", 64'(dut.starve_cnt_q), 64'd0);
    bus.if_req = 1'b0;
    wait_ack(1'b0, "starve_last_dm_timeout");
    bus.dm_req = 1'b0;
    check("starve_cnt_hold", 64'(dut.starve_cnt_q), 64'd0);

    // Wait states on a fetch.
    fetch_only(32'h0000_0400, 32'h0BAD_F00D, 5);

    // Reset in the middle of a data read, then a stray mem_ready.
    resp_delay = 20;
    exp_g.push_back('{1'b0, 32'h0000_0088, 32'd0});
    @(negedge clk);
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0088;
    for (int n = 0; n < 10 && !bus.mem_req; n++) @(negedge clk);
    check("pre_rst_busy", 64'(bus.mem_req), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_req", 64'(bus.mem_req), 64'd0);
    check("rst_async_state", 64'(dut.state_q), 64'd0);
    bus.dm_req = 1'b0;
    @(negedge clk);
    rst         = 1'b0;
    ready_force = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'({bus.mem_req, bus.dm_ack}), 64'd0);
    check("post_rst_state", 64'(dut.state_q), 64'd0);
    ready_force = 1'b0;

    // Early drop: request withdrawn after grant still completes once.
    resp_delay = 2;
    resp_data  = 32'h5A5A_5A5A;
    exp_g.push_back('{1'b0, 32'h0000_0090, 32'd0});
    exp_dm.push_back(32'h5A5A_5A5A);
    @(negedge clk);
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0090;
    @(negedge clk);
    bus.dm_req = 1'b0;
    wait_ack(1'b0, "early_drop_ack_timeout");
    repeat (4) @(negedge clk);
    check("early_drop_no_regrant", 64'(bus.mem_req), 64'd0);

    check("grants_drained", 64'(exp_g.size()),  64'd0);
    check("if_acks_drained", 64'(exp_if.size()), 64'd0);
    check("dm_acks_drained", 64'(exp_dm.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the width of the memory address.
REQ-002 Parameter DATA_W, default 32, sets the width of the memory data.
REQ-003 Parameter STARVE_MAX, default 4, sets the number of consecutive data grants made while a fetch is pending before the fetch is forced.
REQ-004 clk  input  1  Single clock; all state updates on its rising edge.
REQ-005 rst  input  1  Asynchronous, active-high reset.
REQ-006 if_req  input  1  Instruction-fetch request; held high until if_ack.
REQ-007 if_addr  input  ADDR_W  Fetch address.
REQ-008 if_rdata  output  DATA_W  Fetched word, registered.
REQ-009 if_ack  output  1  One-cycle pulse when if_rdata is valid.
REQ-010 if_stall  output  1  Fetch stall to the hazard unit.
REQ-011 dm_req  input  1  Data-memory request; held high until dm_ack.
REQ-012 dm_we  input  1  Selects write when 1, read when 0.
REQ-013 dm_addr  input  ADDR_W  Data address.
REQ-014 dm_wdata  input  DATA_W  Store data.
REQ-015 dm_rdata  output  DATA_W  Load data, registered.
REQ-016 dm_ack  output  1  One-cycle pulse on data completion, for both reads and writes.
REQ-017 dm_stall  output  1  Memory-stage stall to the hazard unit.
REQ-018 mem_req  output  1  Shared-port request, registered.
REQ-019 mem_we  output  1  Shared-port write enable, registered.
REQ-020 mem_addr  output  ADDR_W  Shared-port address, registered.
REQ-021 mem_wdata  output  DATA_W  Shared-port write data, registered.
REQ-022 mem_rdata  input  DATA_W  Shared-port read data; valid when mem_ready=1.
REQ-023 mem_ready  input  1  Shared-port completion; may arrive any number of cycles after mem_req, minimum 1.

Function
REQ-024 The FSM SHALL have three states: IDLE, IF_BUSY and DM_BUSY.
REQ-025 In IDLE, a request is eligible when its req=1 and its ack is not high in the same cycle.
REQ-026 In IDLE, arbitration SHALL grant data first, except that fetch wins when if_req is eligible and starve_cnt==STARVE_MAX.
REQ-027 On grant, at the next edge the block SHALL register mem_req=1 and latch mem_addr, mem_we and mem_wdata from the winner, then enter the matching BUSY state; fetch grants drive mem_we=0.
REQ-028 In a BUSY state, mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until an edge at which mem_ready=1.
REQ-029 At that edge the block SHALL clear mem_req, return to IDLE, pulse the winner's ack for exactly one cycle, and load mem_rdata into the winner's rdata register; dm_rdata is left unchanged on writes.
REQ-030 Minimum latency: req high at cycle n, mem_req high at n+1, mem_ready at n+1, ack at n+2.
REQ-031 In the ack cycle the FSM is already in IDLE and MAY grant the other requester, giving back-to-back service with no idle cycle.
REQ-032 A requester that drops req mid-transaction SHALL NOT abort the transaction; it completes and the ack still pulses.
REQ-033 starve_cnt SHALL increment, saturating at STARVE_MAX, on each data grant made while if_req=1.
REQ-034 starve_cnt SHALL clear on each fetch grant.
REQ-035 starve_cnt SHALL hold otherwise.
REQ-036 if_stall = if_req & ~if_ack, combinational.
REQ-037 dm_stall = dm_req & ~dm_ack, combinational.
REQ-038 mem_ready=1 while in IDLE SHALL be ignored.
REQ-039 Simultaneous eligible requests with starve_cnt<STARVE_MAX SHALL grant data.

Reset
REQ-040 While rst=1, the block SHALL immediately hold state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0 and starve_cnt=0.
REQ-041 A reset asserted mid-transaction SHALL abandon the transaction with no ack; a mem_ready after reset release SHALL be ignored.

Verification
REQ-042 Fetch alone: if_req=1, if_addr=0x100, mem_ready one cycle after mem_req, mem_rdata=0x2402000A -> mem_addr=0x100, mem_we=0, if_ack pulses at n+2, if_rdata=0x2402000A, if_stall high for 2 cycles.
REQ-043 Contention: if_req and dm_req rise together, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> data served first (mem_we=1); fetch granted in the dm_ack cycle; dm_rdata unchanged.
REQ-044 Starvation: if_req held and dm_req reasserted immediately after every ack -> exactly 4 data grants, then a fetch grant, after which starve_cnt=0.
REQ-045 Wait states: mem_ready delayed 5 cycles -> mem_* outputs stable throughout, stall high, ack pulses once.
REQ-046 Reset mid-read: rst pulsed while in DM_BUSY, then mem_ready=1 -> mem_req=0 immediately, no dm_ack, state IDLE.
REQ-047 Early drop: dm_req deasserted 1 cycle after grant -> transaction completes, dm_ack pulses once, no regrant.
